// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions used by the fetch stage and its PC register.
package rv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        PCSRC_PLUS4  = 2'b00,
        PCSRC_TARGET = 2'b01,
        PCSRC_JALR   = 2'b10
    } pcsrc_t;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter with enable, synchronous reset and the next-PC select mux.
import rv32_pkg::*;

module pc_register #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
);

    assign pc_plus4 = pc + XLEN'(4);

    // Encoding 11 is unused and falls back to sequential fetch.
    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc_t'(pc_src))
            PCSRC_TARGET: next_pc = pc_target;
            PCSRC_JALR:   next_pc = {alu_result[XLEN-1:1], 1'b0};
            default:      next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
        end else if (en) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I IF stage: PC, next-PC select, IF/ID register, stall/flush and boot FSM.
// Optional misaligned-redirect trap with HALT state is enabled by `define ALIGN_CHECK_EN.
import rv32_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            MisalignF,
    output fetch_state_t    fetch_state
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_plus4, next_pc;
    logic            pc_en, load_bubble, redirect, target_misaligned, set_misalign;

    pc_register #(
        .RESET_VECTOR(RESET_VECTOR),
        .XLEN        (XLEN)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .en        (pc_en),
        .pc_src    (PCSrc),
        .pc_target (PCTargetE),
        .alu_result(ALUResultE),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc)
    );

    assign imem_addr         = pc;
    assign fetch_state       = state;
    assign redirect          = (PCSrc == 2'b01) || (PCSrc == 2'b10);
    assign target_misaligned = redirect && (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // A redirect always moves the PC, even while the hazard unit stalls fetch.
    always_comb begin
        state_next   = state;
        pc_en        = 1'b0;
        load_bubble  = 1'b0;
        set_misalign = 1'b0;
        case (state)
            BOOT: begin
                load_bubble = 1'b1;
                state_next  = RUN;
            end
            RUN: begin
                pc_en = !StallF || redirect;
`ifdef ALIGN_CHECK_EN
                if (target_misaligned) begin
                    pc_en        = 1'b0;
                    set_misalign = 1'b1;
                    state_next   = HALT;
                end
`endif
            end
            default: begin
                load_bubble = 1'b1;
            end
        endcase
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            MisalignF <= 1'b0;
        end else if (set_misalign) begin
            MisalignF <= 1'b1;
        end
    end
`else
    logic unused_align;
    assign unused_align = target_misaligned ^ set_misalign;
    assign MisalignF    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD || load_bubble) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= imem_rdata;
            PCD      <= pc;
            PCPlus4D <= pc_plus4;
            ValidD   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, redirects, stalls, flushes, reset and alignment trap.
import rv32_pkg::*;

module tb_fetch_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   PCSrc;
    logic [31:0]  PCTargetE, ALUResultE;
    logic         StallF, StallD, FlushD;
    logic [31:0]  imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
    logic         ValidD, MisalignF;
    fetch_state_t fetch_state;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Instruction memory returns an address-tagged word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    assign imem_rdata = word_at(imem_addr);

    fetch_stage #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc      (PCSrc),
        .PCTargetE  (PCTargetE),
        .ALUResultE (ALUResultE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .MisalignF  (MisalignF),
        .fetch_state(fetch_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCSrc = 2'b00; PCTargetE = '0; ALUResultE = '0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_instr", InstrD, 32'h0000_0013);
        check("rst_pcd",   PCD, 32'h0);
        check("rst_pc4d",  PCPlus4D, 32'h0);
        check("rst_valid", {31'b0, ValidD}, 32'h0);
        check("rst_mis",   {31'b0, MisalignF}, 32'h0);
        check("rst_state", 32'(fetch_state), 32'(BOOT));

        rst = 1'b0;
        tick();
        check("boot_addr",  imem_addr, 32'h0);
        check("boot_valid", {31'b0, ValidD}, 32'h0);
        check("boot_state", 32'(fetch_state), 32'(RUN));
        tick();
        check("seq4_addr",  imem_addr, 32'h4);
        check("seq4_instr", InstrD, 32'hCAFE_0000);
        check("seq4_pcd",   PCD, 32'h0);
        check("seq4_pc4d",  PCPlus4D, 32'h4);
        check("seq4_valid", {31'b0, ValidD}, 32'h1);
        tick();
        check("seq8_addr",  imem_addr, 32'h8);
        check("seq8_instr", InstrD, 32'hCAFE_0004);
        tick();
        check("seqc_addr",  imem_addr, 32'hC);
        check("seqc_instr", InstrD, 32'hCAFE_0008);
        tick();
        check("seq10_addr", imem_addr, 32'h10);

        // Branch redirect with hazard-unit flush.
        PCSrc = 2'b01; PCTargetE = 32'h40; FlushD = 1'b1;
        tick();
        check("br_addr",  imem_addr, 32'h40);
        check("br_instr", InstrD, 32'h0000_0013);
        check("br_valid", {31'b0, ValidD}, 32'h0);
        idle();
        tick();
        check("br_tgt_addr",  imem_addr, 32'h44);
        check("br_tgt_instr", InstrD, 32'hCAFE_0040);
        check("br_tgt_pcd",   PCD, 32'h40);

        // jalr target with bit0 cleared.
        PCSrc = 2'b10; ALUResultE = 32'h0000_0101;
        tick();
        check("jalr_addr",  imem_addr, 32'h100);
        check("jalr_instr", InstrD, 32'hCAFE_0044);
        idle();
        tick();
        check("jalr_tgt_instr", InstrD, 32'hCAFE_0100);

        PCSrc = 2'b01; PCTargetE = 32'h1C; FlushD = 1'b1;
        tick();
        idle();
        tick();
        check("pre_stall_addr", imem_addr, 32'h20);
        check("pre_stall_pcd",  PCD, 32'h1C);

        StallF = 1'b1; StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  imem_addr, 32'h20);
            check("stall_instr", InstrD, 32'hCAFE_001C);
            check("stall_pcd",   PCD, 32'h1C);
        end
        idle();
        tick();
        check("release_addr",  imem_addr, 32'h24);
        check("release_instr", InstrD, 32'hCAFE_0020);
        check("release_pcd",   PCD, 32'h20);

        // Redirect overrides a fetch stall.
        StallF = 1'b1; StallD = 1'b1; PCSrc = 2'b01; PCTargetE = 32'h80;
        tick();
        check("rdst_addr",  imem_addr, 32'h80);
        check("rdst_instr", InstrD, 32'hCAFE_0020);
        idle();
        tick();
        check("rdst_tgt_instr", InstrD, 32'hCAFE_0080);

        StallD = 1'b1; FlushD = 1'b1;
        tick();
        check("fl_st_addr",  imem_addr, 32'h88);
        check("fl_st_instr", InstrD, 32'h0000_0013);
        check("fl_st_valid", {31'b0, ValidD}, 32'h0);
        FlushD = 1'b0; StallF = 1'b1;
        tick();
        check("hold_addr", imem_addr, 32'h88);

        // Reset during stall.
        rst = 1'b1;
        tick();
        check("rst_mid_addr",  imem_addr, 32'h0);
        check("rst_mid_state", 32'(fetch_state), 32'(BOOT));
        rst = 1'b0; idle();
        tick();
        tick();
        check("reboot_addr",  imem_addr, 32'h4);
        check("reboot_instr", InstrD, 32'hCAFE_0000);

        // Misaligned redirect target.
        PCSrc = 2'b01; PCTargetE = 32'h42; FlushD = 1'b1;
        tick();
`ifdef ALIGN_CHECK_EN
        check("mis_addr",  imem_addr, 32'h4);
        check("mis_flag",  {31'b0, MisalignF}, 32'h1);
        check("mis_state", 32'(fetch_state), 32'(HALT));
        check("mis_valid", {31'b0, ValidD}, 32'h0);
        idle();
        PCSrc = 2'b01; PCTargetE = 32'h40;
        tick();
        check("halt_addr",  imem_addr, 32'h4);
        check("halt_valid", {31'b0, ValidD}, 32'h0);
        check("halt_flag",  {31'b0, MisalignF}, 32'h1);
        idle();
        tick();
        check("halt2_valid", {31'b0, ValidD}, 32'h0);
        check("halt2_instr", InstrD, 32'h0000_0013);
`else
        check("mis_addr", imem_addr, 32'h42);
        check("mis_flag", {31'b0, MisalignF}, 32'h0);
        idle();
        tick();
        check("mis_next_addr",  imem_addr, 32'h46);
        check("mis_next_instr", InstrD, 32'hCAFE_0042);
        check("mis_next_valid", {31'b0, ValidD}, 32'h1);
        PCSrc = 2'b01; PCTargetE = 32'h40;
        tick();
        check("mis_recover_addr", imem_addr, 32'h40);
        idle();
`endif

        rst = 1'b1;
        tick();
        check("rst2_flag", {31'b0, MisalignF}, 32'h0);
        rst = 1'b0;
        tick();

        // PC+4 wraps modulo 2^32.
        PCSrc = 2'b01; PCTargetE = 32'hFFFF_FFFC;
        tick();
        check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
        idle();
        tick();
        check("wrap_addr",  imem_addr, 32'h0);
        check("wrap_instr", InstrD, 32'h3501_FFFC);
        check("wrap_pc4d",  PCPlus4D, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
